// File: rtl/cpu_bus_arbiter_pkg.sv
// ============================================================================
// Module  : cpu_bus_pkg
// Purpose : Shared types and constants for the instruction/data bus arbiter.
//           - Arbiter FSM state encoding (IDLE/ADDR/DATA/DONE)
//           - Transaction owner encoding (OWN_INST/OWN_DATA)
//           - Byte-enable pattern used for instruction fetches
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package cpu_bus_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        DONE = 2'd3
    } arb_state_t;

    typedef enum logic {
        OWN_INST = 1'b0,
        OWN_DATA = 1'b1
    } arb_owner_t;

    // Fetches always read a full word.
    localparam logic [3:0] SEL_WORD = 4'b1111;

    // Width of the fairness run counter.
    localparam int RUN_CNT_W = 3;

endpackage : cpu_bus_pkg

`default_nettype wire

// File: rtl/cpu_bus_arbiter_grant_sel.sv
// ============================================================================
// Module  : bus_grant_sel
// Purpose : Combinational grant pick between the fetch and the memory-stage
//           ports. The data port normally wins because its instruction is
//           older; i_fair_force lets a waiting fetch win a tie instead.
// Ports   : i_inst_req    in  1  fetch request
//           i_data_req    in  1  load/store request
//           i_fair_force  in  1  give a tie to the fetch port
//           o_grant_inst  out 1  fetch port selected
//           o_grant_data  out 1  data port selected
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module bus_grant_sel (
    input  logic i_inst_req,
    input  logic i_data_req,
    input  logic i_fair_force,
    output logic o_grant_inst,
    output logic o_grant_data
);

    always_comb begin
        o_grant_data = 1'b0;
        o_grant_inst = 1'b0;
        if (i_data_req && !(i_fair_force && i_inst_req)) begin
            o_grant_data = 1'b1;
        end else if (i_inst_req) begin
            o_grant_inst = 1'b1;
        end
    end

endmodule : bus_grant_sel

`default_nettype wire

// File: rtl/cpu_bus_arbiter.sv
// ============================================================================
// Module  : cpu_bus_arbiter
// Purpose : Shares one SRAM-like bus between the fetch port and the
//           memory-stage data port. Each access runs IDLE -> ADDR -> DATA ->
//           DONE; one transaction is outstanding at a time. Data port has
//           priority. Read data is returned on a one-cycle ready pulse and
//           per-port stall requests go to the hazard unit.
// Config  : `define ARB_FAIR_EN enables the fairness counter: after MAX_RUN
//           data grants made while a fetch waits, the fetch wins one tie.
// Params  : MAX_RUN      consecutive data grants before a fetch wins (1..7)
// Ports   : clk          in  1   clock, rising edge
//           rst          in  1   asynchronous active-high reset
//           inst_req     in  1   fetch request, held until inst_ready
//           inst_addr    in  32  fetch byte address
//           inst_rdata   out 32  fetched word, valid with inst_ready
//           inst_ready   out 1   fetch completion pulse
//           data_req     in  1   load/store request, held until data_ready
//           data_wr      in  1   1=store 0=load
//           data_sel     in  4   byte enables
//           data_addr    in  32  data byte address
//           data_wdata   in  32  store data
//           data_rdata   out 32  load word, valid with data_ready
//           data_ready   out 1   data completion pulse
//           stall_inst   out 1   inst_req & ~inst_ready
//           stall_data   out 1   data_req & ~data_ready
//           bus_req      out 1   address-phase request
//           bus_wr       out 1   write flag
//           bus_sel      out 4   byte enables
//           bus_addr     out 32  address
//           bus_wdata    out 32  write data
//           bus_addr_ok  in  1   slave accepted address phase
//           bus_data_ok  in  1   slave completed data phase
//           bus_rdata    in  32  read data, valid with bus_data_ok
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module cpu_bus_arbiter
    import cpu_bus_pkg::*;
#(
    parameter int MAX_RUN = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    output logic [31:0] inst_rdata,
    output logic        inst_ready,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [3:0]  data_sel,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic [31:0] data_rdata,
    output logic        data_ready,
    output logic        stall_inst,
    output logic        stall_data,
    output logic        bus_req,
    output logic        bus_wr,
    output logic [3:0]  bus_sel,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic        bus_addr_ok,
    input  logic        bus_data_ok,
    input  logic [31:0] bus_rdata
);

    if (MAX_RUN < 1 || MAX_RUN > 7) begin : g_maxRunCheck
        $error("cpu_bus_arbiter: MAX_RUN must be in 1..7");
    end

    arb_state_t  r_state;
    arb_state_t  w_stateNext;
    arb_owner_t  r_owner;
    logic        r_wr;
    logic [3:0]  r_sel;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_rdata;

    logic        w_grantInst;
    logic        w_grantData;
    logic        w_fairForce;
    logic        w_grant;
    logic        w_capture;
    logic        w_done;

    // ------------------------------------------------------------------
    // Grant selection
    // ------------------------------------------------------------------
    bus_grant_sel u_grantSel (
        .i_inst_req   (inst_req),
        .i_data_req   (data_req),
        .i_fair_force (w_fairForce),
        .o_grant_inst (w_grantInst),
        .o_grant_data (w_grantData)
    );

    // A grant is only taken in IDLE, which keeps a single transaction in flight.
    assign w_grant = (r_state == IDLE) && (w_grantInst || w_grantData);

`ifdef ARB_FAIR_EN
    localparam logic [RUN_CNT_W-1:0] c_MAX_RUN = RUN_CNT_W'(MAX_RUN);

    logic [RUN_CNT_W-1:0] r_runCnt;

    // Counts data grants that made a waiting fetch lose; any fetch grant
    // restarts the run.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_runCnt <= '0;
        end else if (w_grant) begin
            if (w_grantInst) begin
                r_runCnt <= '0;
            end else if (inst_req && (r_runCnt != c_MAX_RUN)) begin
                r_runCnt <= r_runCnt + 1'b1;
            end
        end
    end

    assign w_fairForce = (r_runCnt == c_MAX_RUN);
`else
    assign w_fairForce = 1'b0;
`endif

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            IDLE: begin
                if (w_grant) begin
                    w_stateNext = ADDR;
                end
            end
            ADDR: begin
                if (bus_addr_ok) begin
                    w_stateNext = bus_data_ok ? DONE : DATA;
                end
            end
            DATA: begin
                if (bus_data_ok) begin
                    w_stateNext = DONE;
                end
            end
            DONE: begin
                w_stateNext = IDLE;
            end
            default: begin
                w_stateNext = IDLE;
            end
        endcase
    end

    // Read data arrives with data_ok, either together with addr_ok in ADDR
    // or later in DATA. Writes leave r_rdata untouched.
    assign w_capture = !r_wr &&
                       (((r_state == ADDR) && bus_addr_ok && bus_data_ok) ||
                        ((r_state == DATA) && bus_data_ok));

    // ------------------------------------------------------------------
    // Request latch: the bus is driven only from these registers so the
    // requesting stage may change or drop its inputs after the grant.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_owner <= OWN_INST;
            r_wr    <= 1'b0;
            r_sel   <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else if (w_grant) begin
            if (w_grantData) begin
                r_owner <= OWN_DATA;
                r_wr    <= data_wr;
                r_sel   <= data_sel;
                r_addr  <= data_addr;
                r_wdata <= data_wdata;
            end else begin
                r_owner <= OWN_INST;
                r_wr    <= 1'b0;
                r_sel   <= SEL_WORD;
                r_addr  <= inst_addr;
                r_wdata <= '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rdata <= '0;
        end else if (w_capture) begin
            r_rdata <= bus_rdata;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign w_done     = (r_state == DONE);
    assign inst_ready = w_done && (r_owner == OWN_INST);
    assign data_ready = w_done && (r_owner == OWN_DATA);
    assign inst_rdata = r_rdata;
    assign data_rdata = r_rdata;
    assign stall_inst = inst_req && !inst_ready;
    assign stall_data = data_req && !data_ready;

    assign bus_req    = (r_state == ADDR);
    assign bus_wr     = r_wr;
    assign bus_sel    = r_sel;
    assign bus_addr   = r_addr;
    assign bus_wdata  = r_wdata;

endmodule : cpu_bus_arbiter

`default_nettype wire

// File: tb/tb_cpu_bus_arbiter.sv
// ============================================================================
// Module  : tb_cpu_bus_arbiter
// Purpose : Self-checking bench for cpu_bus_arbiter. A behavioural bus slave
//           with programmable address/data latency answers the DUT; expected
//           completions are queued per port when a request is driven and
//           compared when the matching ready pulse appears.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cpu_bus_arbiter;

    logic        clk;
    logic        rst;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic [31:0] inst_rdata;
    logic        inst_ready;
    logic        data_req;
    logic        data_wr;
    logic [3:0]  data_sel;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic [31:0] data_rdata;
    logic        data_ready;
    logic        stall_inst;
    logic        stall_data;
    logic        bus_req;
    logic        bus_wr;
    logic [3:0]  bus_sel;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_addr_ok;
    logic        bus_data_ok;
    logic [31:0] bus_rdata;

    cpu_bus_arbiter #(.MAX_RUN(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .inst_req    (inst_req),
        .inst_addr   (inst_addr),
        .inst_rdata  (inst_rdata),
        .inst_ready  (inst_ready),
        .data_req    (data_req),
        .data_wr     (data_wr),
        .data_sel    (data_sel),
        .data_addr   (data_addr),
        .data_wdata  (data_wdata),
        .data_rdata  (data_rdata),
        .data_ready  (data_ready),
        .stall_inst  (stall_inst),
        .stall_data  (stall_data),
        .bus_req     (bus_req),
        .bus_wr      (bus_wr),
        .bus_sel     (bus_sel),
        .bus_addr    (bus_addr),
        .bus_wdata   (bus_wdata),
        .bus_addr_ok (bus_addr_ok),
        .bus_data_ok (bus_data_ok),
        .bus_rdata   (bus_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct { bit wr; logic [31:0] addr; } cmp_t;
    typedef struct { bit wr; logic [3:0] sel; logic [31:0] addr; logic [31:0] wdata; } bus_t;
    typedef struct {
        bit isData; bit wr; logic [3:0] sel; logic [31:0] addr; logic [31:0] wdata;
        int aLat; int dLat; logic [31:0] expRdata;
    } vec_t;

    cmp_t instQ[$];
    cmp_t dataQ[$];
    bus_t busQ[$];
    byte  orderQ[$];

    int checks = 0;
    int errors = 0;

    // Slave side
    bit          slvEn = 1'b1;
    int          slvA = 0;
    int          slvD = 0;
    logic        slvAddrOk, slvDataOk, manAddrOk, manDataOk;
    logic [31:0] slvRdata;
    assign bus_addr_ok = slvEn ? slvAddrOk : manAddrOk;
    assign bus_data_ok = slvEn ? slvDataOk : manDataOk;
    assign bus_rdata   = slvRdata;

    function automatic logic [31:0] memFn(input logic [31:0] a);
        if (a == 32'hBFC0_0000) return 32'h3C08_0001;
        return a ^ 32'h5A5A_0F0F;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic fail(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        errors++;
        $display("FAIL %s actual=%h required=%h", name, act, exp);
    endtask

    // Match the accepted address phase against the expected bus transactions.
    task automatic busLookup();
        int idx = -1;
        foreach (busQ[i]) if (idx < 0 && busQ[i].addr == bus_addr) idx = i;
        if (idx < 0) begin
            fail("bus_addr_unexpected", bus_addr, 32'h0);
        end else begin
            chk("bus_wr", {31'b0, bus_wr}, {31'b0, busQ[idx].wr});
            chk("bus_sel", {28'b0, bus_sel}, {28'b0, busQ[idx].sel});
            if (busQ[idx].wr) chk("bus_wdata", bus_wdata, busQ[idx].wdata);
            busQ.delete(idx);
        end
    endtask

    // Behavioural slave: addr_ok after slvA cycles of bus_req, data_ok slvD
    // cycles later (same cycle when slvD==0). Writes return junk read data.
    initial begin
        int ph = 0;
        int cnt = 0;
        bit wrL;
        logic [31:0] addrL;
        slvAddrOk = 1'b0; slvDataOk = 1'b0; slvRdata = '0;
        forever begin
            @(posedge clk); #1;
            slvAddrOk = 1'b0;
            slvDataOk = 1'b0;
            if (rst || !slvEn) begin
                ph = 0; cnt = 0;
            end else if (ph == 0) begin
                if (bus_req) begin
                    if (cnt >= slvA) begin
                        slvAddrOk = 1'b1;
                        busLookup();
                        wrL = bus_wr; addrL = bus_addr; cnt = 0;
                        if (slvD == 0) begin
                            slvDataOk = 1'b1;
                            slvRdata  = wrL ? 32'hDEAD_DEAD : memFn(addrL);
                        end else ph = 1;
                    end else cnt++;
                end
            end else begin
                cnt++;
                if (cnt >= slvD) begin
                    slvDataOk = 1'b1;
                    slvRdata  = wrL ? 32'hDEAD_DEAD : memFn(addrL);
                    ph = 0; cnt = 0;
                end
            end
        end
    end

    // Completion monitor with its own model of the last read word.
    initial begin
        cmp_t e;
        logic [31:0] mdl = '0;
        logic [31:0] exp;
        forever begin
            @(negedge clk);
            if (rst) mdl = '0;
            if (inst_ready && data_ready) fail("both_ready", 32'h1, 32'h0);
            if (inst_ready) begin
                if (instQ.size() == 0) fail("inst_ready_unexpected", 32'h1, 32'h0);
                else begin
                    e = instQ.pop_front();
                    exp = e.wr ? mdl : memFn(e.addr);
                    chk("inst_rdata", inst_rdata, exp);
                    if (!e.wr) mdl = exp;
                    orderQ.push_back("I");
                end
            end
            if (data_ready) begin
                if (dataQ.size() == 0) fail("data_ready_unexpected", 32'h1, 32'h0);
                else begin
                    e = dataQ.pop_front();
                    exp = e.wr ? mdl : memFn(e.addr);
                    chk("data_rdata", data_rdata, exp);
                    if (!e.wr) mdl = exp;
                    orderQ.push_back("D");
                end
            end
        end
    end

    // Drive n back-to-back requests on one port, holding req between them.
    task automatic runPort(input bit isData, input int n, input bit wr, input logic [3:0] sel,
                           input logic [31:0] addr0, input logic [31:0] wdata,
                           output logic [31:0] got);
        cmp_t c;
        bus_t b;
        int   k;
        got = '0;
        @(posedge clk); #1;
        for (int i = 0; i < n; i++) begin
            c.wr = isData ? wr : 1'b0;
            c.addr = addr0 + 32'(4 * i);
            b.wr = c.wr; b.sel = isData ? sel : 4'hF; b.addr = c.addr; b.wdata = wdata;
            busQ.push_back(b);
            if (isData) begin
                data_wr = wr; data_sel = sel; data_addr = c.addr; data_wdata = wdata;
                data_req = 1'b1; dataQ.push_back(c);
            end else begin
                inst_addr = c.addr; inst_req = 1'b1; instQ.push_back(c);
            end
            k = 0;
            do begin @(negedge clk); k++; end
            while (!(isData ? data_ready : inst_ready) && k < 200);
            if (!(isData ? data_ready : inst_ready))
                fail(isData ? "data_timeout" : "inst_timeout", 32'(k), 32'd200);
            got = isData ? data_rdata : inst_rdata;
            @(posedge clk); #1;
        end
        if (isData) data_req = 1'b0; else inst_req = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vecs[6];
        logic [31:0] got, g1, g2;
        cmp_t        c;
        bus_t        b;
        string       expOrd;

        vecs[0] = '{0, 0, 4'hF, 32'h0000_1000, 32'h0, 0, 0, 32'h5A5A_1F0F};
        vecs[1] = '{1, 0, 4'hF, 32'h8000_0020, 32'h0, 1, 0, 32'hDA5A_0F2F};
        vecs[2] = '{1, 1, 4'hC, 32'h8000_0040, 32'h1234_5678, 0, 2, 32'hDA5A_0F2F};
        vecs[3] = '{0, 0, 4'hF, 32'h0000_1004, 32'h0, 2, 1, 32'h5A5A_1F0B};
        vecs[4] = '{1, 1, 4'h1, 32'h8000_0044, 32'hAABB_CCDD, 3, 0, 32'h5A5A_1F0B};
        vecs[5] = '{1, 0, 4'hF, 32'h8000_0048, 32'h0, 0, 3, 32'hDA5A_0F47};

        rst = 1'b1; inst_req = 0; inst_addr = 0; data_req = 0; data_wr = 0;
        data_sel = 0; data_addr = 0; data_wdata = 0; manAddrOk = 0; manDataOk = 0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_bus_req", {31'b0, bus_req}, 32'h0);
        chk("rst_inst_ready", {31'b0, inst_ready}, 32'h0);
        chk("rst_data_ready", {31'b0, data_ready}, 32'h0);
        chk("rst_bus_addr", bus_addr, 32'h0);
        chk("rst_bus_sel", {28'b0, bus_sel}, 32'h0);
        chk("rst_rdata", data_rdata, 32'h0);
        @(posedge clk); #1 rst = 1'b0;

        // 1: minimum-latency fetch
        slvA = 0; slvD = 0;
        @(posedge clk); #1;
        inst_addr = 32'hBFC0_0000; inst_req = 1'b1;
        c.wr = 0; c.addr = 32'hBFC0_0000; instQ.push_back(c);
        b.wr = 0; b.sel = 4'hF; b.addr = 32'hBFC0_0000; b.wdata = 0; busQ.push_back(b);
        @(negedge clk);
        chk("t1_c0_stall", {31'b0, stall_inst}, 32'h1);
        chk("t1_c0_ready", {31'b0, inst_ready}, 32'h0);
        @(negedge clk);
        chk("t1_c1_bus_req", {31'b0, bus_req}, 32'h1);
        chk("t1_c1_bus_addr", bus_addr, 32'hBFC0_0000);
        chk("t1_c1_stall", {31'b0, stall_inst}, 32'h1);
        @(negedge clk);
        chk("t1_c2_ready", {31'b0, inst_ready}, 32'h1);
        chk("t1_c2_rdata", inst_rdata, 32'h3C08_0001);
        chk("t1_c2_stall", {31'b0, stall_inst}, 32'h0);
        @(posedge clk); #1 inst_req = 1'b0;

        // Table of single transactions
        for (int i = 0; i < 6; i++) begin
            slvA = vecs[i].aLat; slvD = vecs[i].dLat;
            runPort(vecs[i].isData, 1, vecs[i].wr, vecs[i].sel, vecs[i].addr, vecs[i].wdata, got);
            chk($sformatf("vec%0d_rdata", i), got, vecs[i].expRdata);
        end

        // 2: simultaneous requests, data first
        slvA = 0; slvD = 0;
        orderQ.delete();
        fork
            runPort(1'b1, 1, 1'b0, 4'hF, 32'h8000_0010, 32'h0, g1);
            runPort(1'b0, 1, 1'b0, 4'hF, 32'h0000_2000, 32'h0, g2);
            begin
                @(posedge clk); @(negedge clk); @(negedge clk);
                chk("t2_bus_addr", bus_addr, 32'h8000_0010);
            end
        join
        chk("t2_order_len", 32'(orderQ.size()), 32'd2);
        if (orderQ.size() == 2) begin
            chk("t2_first", {24'b0, orderQ[0]}, {24'b0, 8'("D")});
            chk("t2_second", {24'b0, orderQ[1]}, {24'b0, 8'("I")});
        end

        // 3: slow store
        slvA = 2; slvD = 2;
        @(posedge clk); #1;
        c.wr = 1; c.addr = 32'h8000_0080; dataQ.push_back(c);
        b.wr = 1; b.sel = 4'b0011; b.addr = 32'h8000_0080; b.wdata = 32'h0000_BEEF; busQ.push_back(b);
        data_wr = 1; data_sel = 4'b0011; data_addr = 32'h8000_0080; data_wdata = 32'h0000_BEEF;
        data_req = 1'b1;
        for (int cy = 0; cy < 8; cy++) begin
            @(negedge clk);
            chk($sformatf("t3_c%0d_bus_req", cy), {31'b0, bus_req}, {31'b0, (cy >= 1 && cy <= 3)});
            chk($sformatf("t3_c%0d_ready", cy), {31'b0, data_ready}, {31'b0, (cy == 6)});
            chk($sformatf("t3_c%0d_stall", cy), {31'b0, stall_data}, {31'b0, (cy < 6)});
            if (cy >= 1 && cy <= 6) chk($sformatf("t3_c%0d_sel", cy), {28'b0, bus_sel}, 32'h3);
            if (cy == 6) begin @(posedge clk); #1 data_req = 1'b0; end
        end

        // 4: reset in DATA, then a stale data_ok
        @(negedge clk) slvEn = 1'b0;
        @(posedge clk); #1;
        data_wr = 0; data_sel = 4'hF; data_addr = 32'h8000_0100; data_req = 1'b1;
        @(posedge clk); #1 manAddrOk = 1'b1;
        @(negedge clk) chk("t4_addr_bus_req", {31'b0, bus_req}, 32'h1);
        @(posedge clk); #1 manAddrOk = 1'b0;
        @(negedge clk) chk("t4_data_bus_req", {31'b0, bus_req}, 32'h0);
        @(posedge clk); #1 rst = 1'b1; data_req = 1'b0;
        @(negedge clk);
        chk("t4_rst_bus_req", {31'b0, bus_req}, 32'h0);
        chk("t4_rst_data_ready", {31'b0, data_ready}, 32'h0);
        chk("t4_rst_inst_ready", {31'b0, inst_ready}, 32'h0);
        chk("t4_rst_rdata", data_rdata, 32'h0);
        @(posedge clk); #1 rst = 1'b0; manAddrOk = 1'b1; manDataOk = 1'b1;
        @(posedge clk); #1 manAddrOk = 1'b0; manDataOk = 1'b0;
        for (int cy = 0; cy < 3; cy++) begin
            @(negedge clk);
            chk("t4_stale_data_ready", {31'b0, data_ready}, 32'h0);
            chk("t4_stale_bus_req", {31'b0, bus_req}, 32'h0);
        end
        @(negedge clk) slvEn = 1'b1;

        // 5: both ports held high continuously
        slvA = 0; slvD = 0;
        orderQ.delete();
`ifdef ARB_FAIR_EN
        expOrd = "DDDDIDDDDID";
`else
        expOrd = "DDDDDDDDDII";
`endif
        fork
            runPort(1'b1, 9, 1'b0, 4'hF, 32'h8000_0200, 32'h0, g1);
            runPort(1'b0, 2, 1'b0, 4'hF, 32'h0000_3000, 32'h0, g2);
        join
        chk("t5_order_len", 32'(orderQ.size()), 32'd11);
        for (int i = 0; i < 11; i++) begin
            if (i < orderQ.size())
                chk($sformatf("t5_grant%0d", i), {24'b0, orderQ[i]}, {24'b0, expOrd[i]});
        end

        repeat (3) @(posedge clk);
        chk("instQ_empty", 32'(instQ.size()), 32'd0);
        chk("dataQ_empty", 32'(dataQ.size()), 32'd0);
        chk("busQ_empty", 32'(busQ.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_cpu_bus_arbiter

`default_nettype wire
